queue: RTL and testbench
========================

QUEUE -- requirements
Module: queue

Interface
REQ-001 Parameter n, default 3, queue size exponent; capacity SHALL be 2^n persons (8 at default).
REQ-002 clock  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 phcOne  input  1  entry photocell, active-low; a 1->0 transition marks one person entering.
REQ-005 phcTwo  input  1  exit photocell, active-low; a 1->0 transition marks one person leaving.
REQ-006 Tcount  input  2  number of active tellers, 0..3.
REQ-007 Pcount  output  n+1  persons currently in queue, 0..2^n.
REQ-008 Pwait  output  6  estimated wait time, in minutes.
REQ-009 emptyFlag  output  1  high when Pcount==0.
REQ-010 fullFlag  output  1  high when Pcount==2^n.

Function
REQ-011 Each photocell input SHALL be registered once per clock; the previous-sample register SHALL reset to 1.
REQ-012 An entry event SHALL occur on a rising edge where the registered previous phcOne is 1 and the current phcOne is 0; exit events are detected the same way on phcTwo.
REQ-013 A low level held for several cycles SHALL count as exactly one event; a new event requires phc to return to 1.
REQ-014 Pcount SHALL update on the same rising edge that detects the event (0-cycle latency after the sampling edge).
REQ-015 Entry only: Pcount+1 unless fullFlag; when full, the entry is ignored and Pcount holds.
REQ-016 Exit only: Pcount-1 unless emptyFlag; when empty, the exit is ignored and Pcount holds at 0, with no wrap.
REQ-017 Simultaneous entry and exit on one edge: Pcount unchanged when 0<Pcount<2^n; when full, exit only applies (-1); when empty, entry only applies (+1).
REQ-018 Pcount SHALL never exceed 2^n or go below 0.
REQ-019 emptyFlag and fullFlag SHALL be combinational decodes of Pcount.
REQ-020 Pwait SHALL be combinational: Pwait = floor(3*(Pcount+Tcount-1)/Tcount) when Tcount!=0 and Pcount!=0; otherwise Pwait = 0.
REQ-021 Pwait arithmetic SHALL use intermediate width of at least 7 bits, so no overflow occurs; maximum result is 24 (Pcount=8, Tcount=1) and fits 6 bits.
REQ-022 Division SHALL be implemented synthesizably: a case table over Tcount in {1,2,3}, or a constant-divisor divider; no `/` by a variable.
REQ-023 Tcount changes SHALL affect Pwait immediately, with no clock required.

Reset
REQ-024 While reset=1, asynchronously: Pcount=0, emptyFlag=1, fullFlag=0, Pwait=0, and both phc previous-sample registers=1.
REQ-025 Photocell transitions during reset SHALL be ignored; a phc input already low at reset release SHALL NOT count until it returns high and falls again.
REQ-026 Reset asserted mid-operation SHALL clear the count immediately, regardless of clock.

Verification
REQ-027 Reset, then 5 one-cycle-low pulses on phcOne -> Pcount=5, emptyFlag=0, fullFlag=0.
REQ-028 With Pcount=5: Tcount=2 -> Pwait=9; Tcount=3 -> Pwait=7; Tcount=1 -> Pwait=15; Tcount=0 -> Pwait=0.
REQ-029 10 further phcOne pulses -> Pcount saturates at 8, fullFlag=1; Pwait=24 with Tcount=1.
REQ-030 14 phcTwo pulses from full -> Pcount=0, emptyFlag=1; one further phcTwo pulse -> Pcount stays 0, no wrap.
REQ-031 phcOne held low for 5 cycles -> Pcount increments by exactly 1; simultaneous phcOne/phcTwo falls at Pcount=3 -> Pcount stays 3.
REQ-032 reset pulse asserted asynchronously between clock edges at Pcount=6 -> Pcount=0, emptyFlag=1 before the next clock edge.

Source files
------------

// File: rtl/queue.sv
`default_nettype none
// ============================================================================
//  Module   : queue
//  Purpose  : Photocell-driven queue occupancy counter with wait-time estimate
//  Revision : 1.0 - initial release
// ============================================================================
module queue #(
    parameter int n = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         phcOne,
    input  logic         phcTwo,
    input  logic [1:0]   Tcount,
    output logic [n:0]   Pcount,
    output logic [5:0]   Pwait,
    output logic         emptyFlag,
    output logic         fullFlag
);

    localparam logic [n:0] c_CAP = {1'b1, {n{1'b0}}};
    localparam int         c_W   = n + 5;

    logic       r_prev_one;
    logic       r_prev_two;
    logic       r_arm_one;
    logic       r_arm_two;
    logic [n:0] r_count;

    logic       w_entry;
    logic       w_exit;
    logic       w_inc;
    logic       w_dec;

    logic [c_W-1:0] w_sum;
    logic [c_W-1:0] w_num;
    logic [c_W-1:0] w_quot;

    // The arm bits stay clear until a photocell has been seen high after
    // reset, so a beam already broken at reset release is not counted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prev_one <= 1'b1;
            r_prev_two <= 1'b1;
            r_arm_one  <= 1'b0;
            r_arm_two  <= 1'b0;
        end else begin
            r_prev_one <= phcOne;
            r_prev_two <= phcTwo;
            r_arm_one  <= r_arm_one | phcOne;
            r_arm_two  <= r_arm_two | phcTwo;
        end
    end

    assign w_entry = r_arm_one & r_prev_one & ~phcOne;
    assign w_exit  = r_arm_two & r_prev_two & ~phcTwo;
    assign w_inc   = w_entry & ~fullFlag;
    assign w_dec   = w_exit  & ~emptyFlag;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_inc && !w_dec) begin
            r_count <= r_count + 1'b1;
        end else if (w_dec && !w_inc) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign Pcount    = r_count;
    assign emptyFlag = (r_count == '0);
    assign fullFlag  = (r_count == c_CAP);

    // Divide-by-teller done as a small case table; only the /3 needs a divider.
    always_comb begin
        w_sum  = c_W'(r_count) + c_W'(Tcount) - c_W'(1);
        w_num  = w_sum * c_W'(3);
        w_quot = '0;
        if (!emptyFlag) begin
            case (Tcount)
                2'd1:    w_quot = w_num;
                2'd2:    w_quot = w_num >> 1;
                2'd3:    w_quot = w_num / c_W'(3);
                default: w_quot = '0;
            endcase
        end
    end

    assign Pwait = 6'(w_quot);

endmodule
`default_nettype wire

// File: tb/tb_queue.sv
`default_nettype none
// Testbench for queue: directed scenarios plus randomized photocell traffic
// compared against a saturating-counter reference model.
module tb_queue;

    localparam int N   = 3;
    localparam int CAP = 1 << N;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         phcOne = 1'b1;
    logic         phcTwo = 1'b1;
    logic [1:0]   Tcount = 2'd1;
    logic [N:0]   Pcount;
    logic [5:0]   Pwait;
    logic         emptyFlag;
    logic         fullFlag;

    int n_checks = 0;
    int n_fail   = 0;

    int m_cnt   = 0;
    bit m_last1 = 1'b0;
    bit m_last2 = 1'b0;

    queue #(.n(N)) dut (
        .clock     (clock),
        .reset     (reset),
        .phcOne    (phcOne),
        .phcTwo    (phcTwo),
        .Tcount    (Tcount),
        .Pcount    (Pcount),
        .Pwait     (Pwait),
        .emptyFlag (emptyFlag),
        .fullFlag  (fullFlag)
    );

    always #5 clock = ~clock;

    function automatic int model_wait(input int p, input int t);
        if (t == 0 || p == 0) return 0;
        return (3 * (p + t - 1)) / t;
    endfunction

    // One clock: drive photocells at the falling edge, advance the model at
    // the rising edge. A fall is a level change 1->0 between two observed edges;
    // after reset the last observed level is treated as low.
    task automatic cycle(input logic p1, input logic p2);
        bit e1, e2;
        @(negedge clock);
        phcOne = p1;
        phcTwo = p2;
        @(posedge clock);
        e1 = m_last1 && !p1;
        e2 = m_last2 && !p2;
        m_last1 = p1;
        m_last2 = p2;
        if (e1 && !e2)      m_cnt = (m_cnt < CAP) ? m_cnt + 1 : CAP;
        else if (e2 && !e1) m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
        else if (e1 && e2) begin
            if (m_cnt == 0)        m_cnt = 1;
            else if (m_cnt == CAP) m_cnt = CAP - 1;
        end
        #1;
    endtask

    task automatic pulse_in();
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
    endtask

    task automatic pulse_out();
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_last1 = 1'b0;
        m_last2 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        Tcount = 2'd3;
        repeat (3) begin
            @(negedge clock);
            phcOne = ~phcOne;
            phcTwo = ~phcTwo;
        end
        #1;
        n_checks++;
        if (Pcount !== 4'd0) begin n_fail++; $display("FAIL reset_pcount: got %0d want 0", Pcount); end
        n_checks++;
        if (emptyFlag !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", emptyFlag); end
        n_checks++;
        if (fullFlag !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", fullFlag); end
        n_checks++;
        if (Pwait !== 6'd0) begin n_fail++; $display("FAIL reset_pwait: got %0d want 0", Pwait); end
        @(negedge clock);
        phcOne = 1'b1;
        phcTwo = 1'b1;
        reset  = 1'b0;
        Tcount = 2'd1;
        model_reset();
        cycle(1'b1, 1'b1);
    endtask

    task automatic test_entry();
        repeat (5) pulse_in();
        n_checks++;
        if (Pcount !== 4'd5) begin n_fail++; $display("FAIL entry5_pcount: got %0d want 5", Pcount); end
        n_checks++;
        if (emptyFlag !== 1'b0 || fullFlag !== 1'b0)
            begin n_fail++; $display("FAIL entry5_flags: got e=%b f=%b want e=0 f=0", emptyFlag, fullFlag); end
    endtask

    task automatic test_pwait();
        int tv[4]  = '{2, 3, 1, 0};
        int exp[4] = '{9, 7, 15, 0};
        for (int i = 0; i < 4; i++) begin
            Tcount = 2'(tv[i]);
            #1;
            n_checks++;
            if (Pwait !== 6'(exp[i]))
                begin n_fail++; $display("FAIL pwait_t%0d: got %0d want %0d", tv[i], Pwait, exp[i]); end
        end
        Tcount = 2'd1;
    endtask

    task automatic test_saturate();
        repeat (10) pulse_in();
        n_checks++;
        if (Pcount !== 4'd8) begin n_fail++; $display("FAIL sat_pcount: got %0d want 8", Pcount); end
        n_checks++;
        if (fullFlag !== 1'b1) begin n_fail++; $display("FAIL sat_full: got %b want 1", fullFlag); end
        n_checks++;
        if (Pwait !== 6'd24) begin n_fail++; $display("FAIL sat_pwait: got %0d want 24", Pwait); end
    endtask

    task automatic test_drain();
        repeat (14) pulse_out();
        n_checks++;
        if (Pcount !== 4'd0 || emptyFlag !== 1'b1)
            begin n_fail++; $display("FAIL drain: got cnt=%0d e=%b want cnt=0 e=1", Pcount, emptyFlag); end
        pulse_out();
        n_checks++;
        if (Pcount !== 4'd0) begin n_fail++; $display("FAIL underflow: got %0d want 0", Pcount); end
        n_checks++;
        if (Pwait !== 6'd0) begin n_fail++; $display("FAIL empty_pwait: got %0d want 0", Pwait); end
    endtask

    task automatic test_hold_and_simultaneous();
        repeat (5) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        n_checks++;
        if (Pcount !== 4'd1) begin n_fail++; $display("FAIL hold_low: got %0d want 1", Pcount); end
        repeat (2) pulse_in();
        cycle(1'b0, 1'b0);
        n_checks++;
        if (Pcount !== 4'd3) begin n_fail++; $display("FAIL simul_mid: got %0d want 3", Pcount); end
        cycle(1'b1, 1'b1);
        repeat (5) pulse_in();
        cycle(1'b0, 1'b0);
        n_checks++;
        if (Pcount !== 4'd7) begin n_fail++; $display("FAIL simul_full: got %0d want 7", Pcount); end
        cycle(1'b1, 1'b1);
        repeat (7) pulse_out();
        cycle(1'b0, 1'b0);
        n_checks++;
        if (Pcount !== 4'd1) begin n_fail++; $display("FAIL simul_empty: got %0d want 1", Pcount); end
        cycle(1'b1, 1'b1);
    endtask

    task automatic test_async_reset();
        repeat (5) pulse_in();
        n_checks++;
        if (Pcount !== 4'd6) begin n_fail++; $display("FAIL pre_async: got %0d want 6", Pcount); end
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (Pcount !== 4'd0 || emptyFlag !== 1'b1)
            begin n_fail++; $display("FAIL async_reset: got cnt=%0d e=%b want cnt=0 e=1", Pcount, emptyFlag); end
        #1 reset = 1'b0;
        model_reset();
        cycle(1'b1, 1'b1);
    endtask

    task automatic test_low_at_release();
        @(negedge clock);
        phcOne = 1'b0;
        reset  = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        repeat (3) cycle(1'b0, 1'b1);
        n_checks++;
        if (Pcount !== 4'd0) begin n_fail++; $display("FAIL low_release: got %0d want 0", Pcount); end
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        n_checks++;
        if (Pcount !== 4'd1) begin n_fail++; $display("FAIL rearm: got %0d want 1", Pcount); end
        cycle(1'b1, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            logic p1, p2;
            if (i < 300) begin
                p1 = ($urandom_range(0, 1) != 0);
                p2 = ($urandom_range(0, 3) != 0);
            end else begin
                p1 = ($urandom_range(0, 3) != 0);
                p2 = ($urandom_range(0, 1) != 0);
            end
            Tcount = 2'($urandom_range(0, 3));
            cycle(p1, p2);
            n_checks++;
            if (Pcount !== (N+1)'(m_cnt))
                begin n_fail++; $display("FAIL rand_pcount[%0d]: got %0d want %0d", i, Pcount, m_cnt); end
            n_checks++;
            if (emptyFlag !== (m_cnt == 0) || fullFlag !== (m_cnt == CAP))
                begin n_fail++; $display("FAIL rand_flags[%0d]: got e=%b f=%b cnt=%0d", i, emptyFlag, fullFlag, m_cnt); end
            n_checks++;
            if (Pwait !== 6'(model_wait(m_cnt, int'(Tcount))))
                begin n_fail++; $display("FAIL rand_pwait[%0d]: got %0d want %0d", i, Pwait, model_wait(m_cnt, int'(Tcount))); end
        end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_pwait();
        test_saturate();
        test_drain();
        test_hold_and_simultaneous();
        test_async_reset();
        test_low_at_release();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
